level_meter_display: RTL and testbench
======================================

# level_meter_display

Display-side consumer of the 5-bit level position stream produced by the PCM-to-position converter. It accepts positions over a valid/ready handshake and applies fast attack to a displayed level with tick-paced release. It also maintains a peak marker with hold time and decay. Outputs are a registered 31-segment bar mask and a one-hot peak segment for the LED/display driver.

## Interface
- HOLD_TICKS, 16: ticks the peak marker is held after a new peak; legal 0..255.
- DECAY_TICKS, 2: ticks per one-step release of the displayed level; legal 1..255.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately.
- i_valid  input  1  producer has a position.
- i_ready  output  1  block can accept; transfer when i_valid && i_ready at a clk edge.
- i_position  input  5  level position 0..31; 0 = silence.
- i_tick  input  1  one-cycle release-timing strobe from an external divider.
- o_level  output  5  current displayed level.
- o_peak  output  5  current peak marker level; always >= o_level.
- o_bar  output  31  o_bar[k] = 1 iff k < o_level.
- o_peak_bar  output  31  one-hot at bit o_peak-1 when o_peak > 0; all zero when o_peak = 0.
- o_update  output  1  one-cycle pulse on any edge where o_level or o_peak changed.

## Operation
- FSM states: IDLE (i_ready=1) and APPLY (i_ready=0).
- IDLE: transfer latches i_position into the sample register and moves to APPLY. Otherwise stays in IDLE.
- APPLY: applies the sample, then returns to IDLE unconditionally.
- Attack, applied in APPLY:
  - If sample > level: level <= sample and the decay counter reloads to DECAY_TICKS.
  - If sample >= peak: peak <= sample and the hold counter reloads to HOLD_TICKS.
- Release, applied on any edge with i_tick=1, in either state:
  - Decay counter decrements. When it would reach 0, it reloads to DECAY_TICKS and level decrements if level > 0. At level 0 it only reloads.
  - If hold counter > 0, it decrements. Otherwise peak <= max(peak-1, level).
- Tick in the same APPLY edge as the sample:
  - Release is computed first; attack is then applied to the released values.
  - An attack reload of a counter overrides that counter's tick update.
- Tick in the same IDLE edge as a transfer: release applies on that edge; the sample applies on the next edge.
- Invariant peak >= level holds after every edge. When level rises above peak, peak follows to the same value.
- o_bar and o_peak_bar are registered, computed from the next-state level/peak, and always consistent with o_level and o_peak in the same cycle.
- o_update is registered and is 1 for exactly the edge following a change in level or peak. It is 0 otherwise, including for an APPLY that changes nothing.
- Sample register holds its value after the handshake, so the producer may change i_position freely.

## Timing
- Reset values:
  - i_ready=1, state IDLE.
  - o_level=0, o_peak=0, o_bar=0, o_peak_bar=0, o_update=0.
  - Sample register=0, decay counter=DECAY_TICKS, hold counter=0.
- Latency: transfer at edge N. Updated outputs and o_update are visible after edge N+1.
- i_ready is low for exactly the one cycle after a transfer.
- Throughput: one position every 2 cycles with i_valid held high.
- Reset asserted mid-APPLY: the pending sample is discarded, all outputs clear asynchronously, and no o_update is produced.
- The first transfer is possible on the first edge after reset deasserts.
- Counters are 8 bits and never wrap below 0.
- Level saturates at 0 on release. Attack is bounded at 31 by the input width.

## Test plan
- **Reset:** hold reset low, then release → i_ready=1; all outputs 0; o_update never pulses.
- **Attack and handshake:** HOLD_TICKS=4, DECAY_TICKS=2; send position 20 at edge N →
  - after N+1: o_level=20, o_peak=20, o_bar=31'h000F_FFFF, o_peak_bar=bit 19.
  - o_update high one cycle; i_ready low exactly one cycle.
- **Release and peak hold**, continuing the previous case; send 8 ticks with no input →
  - o_level: 19 at tick 2, 18 at tick 4, 17 at tick 6, 16 at tick 8.
  - o_peak: 20 through tick 4, 19 at tick 5, 18 at tick 6, 17 at tick 7, 16 at tick 8.
  - o_update pulses on ticks 2, 4, 5, 6, 7 and 8.
- **Sample below level:** level 20, peak 20; send position 10 → no output change, o_update stays 0.
- **Simultaneous tick and APPLY:** level 5 with the decay step due on this tick; send position 5 with i_tick high in its APPLY cycle → o_level stays 5; decay counter reloaded, so the next level step needs two more ticks.
- **Back-to-back and reset:**
  - i_valid held high with positions 3, 7, 12 → accepted on alternating edges; o_level ends at 12.
  - Assert reset in an APPLY cycle → outputs clear immediately; sample lost.

Source files
------------

// File: rtl/level_meter_display_if.sv
// Position stream handshake between the PCM-to-position
// converter and the level meter display.
interface level_meter_display_if;
   logic       i_valid;
   logic       i_ready;
   logic [4:0] i_position;

   modport master (
      output i_valid,
      output i_position,
      input  i_ready
   );

   modport slave (
      input  i_valid,
      input  i_position,
      output i_ready
   );
endinterface

// File: rtl/level_meter_display.sv
// Level meter: fast attack, tick-paced release and a held,
// decaying peak marker driving a 31-segment bar display.
module level_meter_display #(
   parameter int HOLD_TICKS  = 16,
   parameter int DECAY_TICKS = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   level_meter_display_if.slave bus,
   input  logic                 i_tick,
   output logic [4:0]           o_level,
   output logic [4:0]           o_peak,
   output logic [30:0]          o_bar,
   output logic [30:0]          o_peak_bar,
   output logic                 o_update
);

   localparam logic [7:0] DECAY = 8'(DECAY_TICKS);
   localparam logic [7:0] HOLD  = 8'(HOLD_TICKS);

   typedef enum logic {
      IDLE,
      APPLY
   } state_t;

   state_t      state;
   logic        ready;
   logic [4:0]  sample;
   logic [7:0]  dcnt;
   logic [7:0]  hcnt;

   logic [4:0]  lv_r;
   logic [4:0]  pk_r;
   logic [4:0]  pk_dec;
   logic [4:0]  lv_n;
   logic [4:0]  pk_n;
   logic [7:0]  dc_n;
   logic [7:0]  hc_n;
   logic [30:0] bar_n;
   logic [30:0] pbar_n;

   assign bus.i_ready = ready;

   // Release first, then attack on the released values.
   always_comb begin
      lv_r   = o_level;
      pk_r   = o_peak;
      dc_n   = dcnt;
      hc_n   = hcnt;
      pk_dec = (o_peak == 5'd0) ? 5'd0 : o_peak - 5'd1;
      if (i_tick) begin
         if (dcnt <= 8'd1) begin
            dc_n = DECAY;
            if (o_level != 5'd0)
               lv_r = o_level - 5'd1;
         end else begin
            dc_n = dcnt - 8'd1;
         end
         if (hcnt != 8'd0)
            hc_n = hcnt - 8'd1;
         else
            pk_r = (pk_dec > lv_r) ? pk_dec : lv_r;
      end
      lv_n = lv_r;
      pk_n = pk_r;
      if (state == APPLY) begin
         if (sample > lv_r) begin
            lv_n = sample;
            dc_n = DECAY;
         end
         if (sample >= pk_r) begin
            pk_n = sample;
            hc_n = HOLD;
         end
      end
   end

   always_comb begin
      bar_n  = 31'((32'd1 << lv_n) - 32'd1);
      pbar_n = '0;
      if (pk_n != 5'd0)
         pbar_n = 31'(32'd1 << (pk_n - 5'd1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ready      <= 1'b1;
         sample     <= '0;
         dcnt       <= DECAY;
         hcnt       <= '0;
         o_level    <= '0;
         o_peak     <= '0;
         o_bar      <= '0;
         o_peak_bar <= '0;
         o_update   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  sample <= bus.i_position;
                  state  <= APPLY;
                  ready  <= 1'b0;
               end
            end
            APPLY: begin
               state <= IDLE;
               ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
         dcnt       <= dc_n;
         hcnt       <= hc_n;
         o_level    <= lv_n;
         o_peak     <= pk_n;
         o_bar      <= bar_n;
         o_peak_bar <= pbar_n;
         o_update   <= (lv_n != o_level) ||
                       (pk_n != o_peak);
      end
   end

endmodule

// File: tb/tb_level_meter_display.sv
// Scoreboard bench for level_meter_display: directed cases
// plus randomized traffic against an integer reference model.
module tb_level_meter_display;

   localparam int HOLD  = 4;
   localparam int DECAY = 2;

   typedef struct {
      int lv;
      int pk;
      int upd;
      int rdy;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        i_tick;
   logic [4:0]  o_level;
   logic [4:0]  o_peak;
   logic [30:0] o_bar;
   logic [30:0] o_peak_bar;
   logic        o_update;

   level_meter_display_if bus();

   level_meter_display #(
      .HOLD_TICKS (HOLD),
      .DECAY_TICKS(DECAY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .i_tick    (i_tick),
      .o_level   (o_level),
      .o_peak    (o_peak),
      .o_bar     (o_bar),
      .o_peak_bar(o_peak_bar),
      .o_update  (o_update)
   );

   int checks = 0;
   int errors = 0;
   exp_t q[$];

   int m_busy, m_sample, m_lv, m_pk, m_dc, m_hc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, want);
      end
   endtask

   function automatic logic [30:0] bar_of(int n);
      logic [30:0] b;
      for (int k = 0; k < 31; k++)
         b[k] = (k < n);
      return b;
   endfunction

   function automatic logic [30:0] pbar_of(int n);
      logic [30:0] b;
      b = '0;
      if (n > 0)
         b[n-1] = 1'b1;
      return b;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_sample = 0;
      m_lv = 0; m_pk = 0;
      m_dc = DECAY; m_hc = 0;
   endtask

   task automatic model_step(input bit v,
                             input int pos,
                             input bit tk,
                             output exp_t e);
      int nl, np, ndc, nhc;
      nl = m_lv; np = m_pk;
      ndc = m_dc; nhc = m_hc;
      if (tk) begin
         if (m_dc - 1 <= 0) begin
            ndc = DECAY;
            if (nl > 0) nl = nl - 1;
         end else begin
            ndc = m_dc - 1;
         end
         if (m_hc > 0) nhc = m_hc - 1;
         else np = (m_pk - 1 > nl) ? m_pk - 1 : nl;
      end
      if (m_busy != 0) begin
         if (m_sample > nl) begin
            nl = m_sample; ndc = DECAY;
         end
         if (m_sample >= np) begin
            np = m_sample; nhc = HOLD;
         end
      end
      e.upd = (nl != m_lv || np != m_pk) ? 1 : 0;
      if (m_busy != 0) begin
         m_busy = 0;
      end else if (v) begin
         m_busy = 1;
         m_sample = pos;
      end
      m_lv = nl; m_pk = np;
      m_dc = ndc; m_hc = nhc;
      e.lv = nl; e.pk = np;
      e.rdy = (m_busy == 0) ? 1 : 0;
   endtask

   task automatic cycle(input bit v,
                        input int pos,
                        input bit tk);
      exp_t e;
      bus.i_valid    = v;
      bus.i_position = 5'(pos);
      i_tick         = tk;
      model_step(v, pos, tk, e);
      @(posedge clk);
      q.push_back(e);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_level", 32'(o_level), 0);
      chk("rst_peak", 32'(o_peak), 0);
      chk("rst_bar", 32'(o_bar), 0);
      chk("rst_pbar", 32'(o_peak_bar), 0);
      chk("rst_update", 32'(o_update), 0);
      chk("rst_ready", 32'(bus.i_ready), 1);
      q.delete();
      model_reset();
      bus.i_valid = 1'b0;
      i_tick = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("mon_rst_update", 32'(o_update), 0);
            chk("mon_rst_level", 32'(o_level), 0);
         end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("level", 32'(o_level), e.lv);
            chk("peak", 32'(o_peak), e.pk);
            chk("update", 32'(o_update), e.upd);
            chk("ready", 32'(bus.i_ready), e.rdy);
            chk("bar", 32'(o_bar), 32'(bar_of(e.lv)));
            chk("peak_bar", 32'(o_peak_bar),
                32'(pbar_of(e.pk)));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int exp_lv[8];
      int exp_pk[8];
      int exp_up[8];
      exp_lv = '{20, 19, 19, 18, 18, 17, 17, 16};
      exp_pk = '{20, 20, 20, 20, 19, 18, 17, 16};
      exp_up = '{0, 1, 0, 1, 1, 1, 1, 1};
      reset = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_position = '0;
      i_tick = 1'b0;
      @(posedge clk);
      #2;
      do_reset();

      cycle(0, 0, 0);
      chk("idle_update", 32'(o_update), 0);

      cycle(1, 20, 0);
      chk("hs_ready_low", 32'(bus.i_ready), 0);
      chk("hs_no_early", 32'(o_level), 0);
      cycle(0, 0, 0);
      chk("atk_ready_back", 32'(bus.i_ready), 1);
      chk("atk_level", 32'(o_level), 20);
      chk("atk_peak", 32'(o_peak), 20);
      chk("atk_bar", 32'(o_bar), 32'h000F_FFFF);
      chk("atk_pbar", 32'(o_peak_bar), 32'h0008_0000);
      chk("atk_update", 32'(o_update), 1);
      cycle(0, 0, 0);
      chk("atk_update_once", 32'(o_update), 0);

      for (int t = 0; t < 8; t++) begin
         cycle(0, 0, 1);
         chk($sformatf("rel_level_t%0d", t + 1),
             32'(o_level), exp_lv[t]);
         chk($sformatf("rel_peak_t%0d", t + 1),
             32'(o_peak), exp_pk[t]);
         chk($sformatf("rel_upd_t%0d", t + 1),
             32'(o_update), exp_up[t]);
      end

      cycle(1, 10, 0);
      cycle(0, 0, 0);
      chk("below_level", 32'(o_level), 16);
      chk("below_update", 32'(o_update), 0);

      do_reset();
      cycle(1, 5, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      cycle(1, 5, 0);
      cycle(0, 0, 1);
      chk("sim_level", 32'(o_level), 5);
      cycle(0, 0, 1);
      chk("sim_level_t1", 32'(o_level), 5);
      cycle(0, 0, 1);
      chk("sim_level_t2", 32'(o_level), 4);

      do_reset();
      cycle(1, 3, 0);
      cycle(1, 7, 0);
      cycle(1, 7, 0);
      cycle(1, 12, 0);
      cycle(1, 12, 0);
      cycle(0, 0, 0);
      chk("b2b_level", 32'(o_level), 12);
      chk("b2b_peak", 32'(o_peak), 12);

      cycle(1, 25, 0);
      do_reset();
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      chk("lost_sample", 32'(o_level), 0);

      for (int i = 0; i < 600; i++) begin
         int p;
         p = (i % 3 == 0) ? $urandom_range(0, 31)
                          : $urandom_range(0, 8);
         if (i == 300)
            do_reset();
         cycle($urandom_range(0, 2) == 0, p,
               $urandom_range(0, 2) == 0);
      end

      cycle(0, 0, 0);
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
